// File: rtl/nco_pkg.sv
// Shared opcodes, FSM state encoding and address width for the NCO command sequencer.
package nco_pkg;

    localparam int ADDR_W = 13;

    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_STEP = 8'h02;
    localparam logic [7:0] OP_PLAY = 8'h03;
    localparam logic [7:0] OP_STOP = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP_ARG,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_RST_LOAD,
        ST_LOAD_DATA,
        ST_RST_PLAY,
        ST_PLAY
    } state_t;

    function automatic logic len_ok(input logic [ADDR_W-1:0] len, input logic [31:0] max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/nco_strobe_gen.sv
// Free-running 0..STROBE_MAX strobe counter with synchronous clear; ce marks the last count.
module nco_strobe_gen #(
    parameter int STROBE_MAX = 520
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_ce
);

    localparam int CNT_W = (STROBE_MAX < 1) ? 1 : $clog2(STROBE_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_ce;

    assign w_ce = (r_cnt == CNT_W'(STROBE_MAX));
    assign o_ce = w_ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_ce) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nco_seq_ctrl.sv
// Byte-stream command sequencer driving the NCO datapath: table loads paced by a mirrored
// strobe, step programming, and playback start/stop.
module nco_seq_ctrl
    import nco_pkg::*;
#(
    parameter int MAX_ADDR     = 6000,
    parameter int STROBE_MAX   = 520,
    parameter int DEFAULT_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       nco_rst_n_o,
    output logic       nco_we_o,
    output logic [7:0] nco_data_o,
    output logic [7:0] nco_freq_step_o,
    output logic       playing_o,
    output logic       load_done_o,
    output logic       err_o
);

    state_t            r_state;
    logic              r_ret_play;
    logic [4:0]        r_len_hi;
    logic [ADDR_W-1:0] r_remaining;
    logic [7:0]        r_step;
    logic              r_nco_rst_n;
    logic              r_we;
    logic [7:0]        r_data;
    logic [7:0]        r_freq_step;
    logic              r_load_done;
    logic              r_err;

    logic              w_ce;
    logic              w_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_len;

    // The mirror restarts whenever the NCO sees its reset, keeping both strobes in phase.
    nco_strobe_gen #(
        .STROBE_MAX(STROBE_MAX)
    ) u_strobe (
        .clk  (clk),
        .rst  (rst),
        .i_clr(~r_nco_rst_n),
        .o_ce (w_ce)
    );

    assign w_len    = {r_len_hi, cmd_data_i};
    assign w_accept = cmd_valid_i && w_ready;

    // r_nco_rst_n is low only during rst and the one-cycle pulse states, which never accept bytes.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_STEP_ARG, ST_LEN_HI, ST_LEN_LO, ST_PLAY: w_ready = r_nco_rst_n;
            ST_LOAD_DATA: w_ready = w_ce && (r_remaining != '0);
            default:      w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ret_play  <= 1'b0;
            r_len_hi    <= '0;
            r_remaining <= '0;
            r_step      <= 8'(DEFAULT_STEP);
            r_nco_rst_n <= 1'b0;
            r_we        <= 1'b0;
            r_data      <= '0;
            r_freq_step <= '0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_nco_rst_n <= 1'b1;
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_data_i)
                            OP_LOAD: r_state <= ST_LEN_HI;
                            OP_STEP: begin
                                r_state    <= ST_STEP_ARG;
                                r_ret_play <= 1'b0;
                            end
                            OP_PLAY: begin
                                r_state     <= ST_RST_PLAY;
                                r_nco_rst_n <= 1'b0;
                            end
                            OP_STOP: r_err <= 1'b0;
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_STEP_ARG: begin
                    if (w_accept) begin
                        r_step <= cmd_data_i;
                        if (r_ret_play) begin
                            r_freq_step <= cmd_data_i;
                            r_state     <= ST_PLAY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= cmd_data_i[4:0];
                        r_state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        if (len_ok(w_len, 32'(MAX_ADDR))) begin
                            r_remaining <= w_len;
                            r_nco_rst_n <= 1'b0;
                            r_state     <= ST_RST_LOAD;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RST_LOAD: begin
                    r_we    <= 1'b0;
                    r_state <= ST_LOAD_DATA;
                end
                ST_LOAD_DATA: begin
                    // Step stays 0 here so the NCO address only moves on written samples.
                    if (w_ce) begin
                        if (r_remaining != '0) begin
                            if (cmd_valid_i) begin
                                r_data      <= cmd_data_i;
                                r_we        <= 1'b1;
                                r_remaining <= r_remaining - 1'b1;
                            end else begin
                                r_we <= 1'b0;
                            end
                        end else begin
                            r_we        <= 1'b0;
                            r_load_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_RST_PLAY: begin
                    r_freq_step <= r_step;
                    r_state     <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_accept) begin
                        case (cmd_data_i)
                            OP_STEP: begin
                                r_state    <= ST_STEP_ARG;
                                r_ret_play <= 1'b1;
                            end
                            OP_STOP: begin
                                r_freq_step <= '0;
                                r_err       <= 1'b0;
                                r_state     <= ST_IDLE;
                            end
                            OP_PLAY: begin
                                r_freq_step <= '0;
                                r_nco_rst_n <= 1'b0;
                                r_state     <= ST_RST_PLAY;
                            end
                            OP_LOAD: begin
                                r_freq_step <= '0;
                                r_state     <= ST_LEN_HI;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o     = w_ready;
    assign nco_rst_n_o     = r_nco_rst_n;
    assign nco_we_o        = r_we;
    assign nco_data_o      = r_data;
    assign nco_freq_step_o = r_freq_step;
    assign playing_o       = (r_state == ST_PLAY);
    assign load_done_o     = r_load_done;
    assign err_o           = r_err;

endmodule
